// File: rtl/pdu_run_ctrl.sv
// pdu_run_ctrl: run/step clock-enable controller for the CPU core.
// Turns the board run switch and step button into a cpu_ce strobe.
// Supports multi-cycle stepping and NUM_BP PC breakpoints with sticky
// hit flags. The core is always clocked and qualifies on cpu_ce.

// One input channel: a 2-FF synchroniser followed by a debouncer. The
// debounced level follows the synchronised input only after the two have
// disagreed for DB_CNT consecutive cycles; any agreement restarts the count.
module pdu_run_ctrl_sync_db #(
  parameter int DB_CNT = 100000,
  parameter int DB_W   = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            db_q, db_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Next synchroniser stages and disagreement counter.
  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == DB_W'(DB_CNT - 1)) db_d = s2_q;
      else                            cnt_d = cnt_q + 1'b1;
    end
  end

  // Register the channel; reset clears everything to a released input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign level = db_q;
endmodule

// One breakpoint comparator lane.
module pdu_run_ctrl_bp_cmp #(
  parameter int PC_W = 32
) (
  input  logic            en,
  input  logic [PC_W-1:0] addr,
  input  logic [PC_W-1:0] pc,
  output logic            match
);
  assign match = en && (pc == addr);
endmodule

module pdu_run_ctrl #(
  parameter int PC_W   = 32,
  parameter int NUM_BP = 2,
  parameter int STEP_W = 8,
  parameter int DB_CNT = 100000,
  parameter int DB_W   = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   step,
  input  logic [STEP_W-1:0]      step_cnt,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0]        pc,
  output logic                   cpu_ce,
  output logic                   halted,
  output logic [NUM_BP-1:0]      bp_hit,
  output logic [31:0]            cycle_cnt
);
  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                halted_q, halted_d;
  logic                run_armed_q, run_armed_d;
  logic                resume_mask_q, resume_mask_d;
  logic                step_prev_q, step_prev_d;
  logic [NUM_BP-1:0]   bp_hit_q, bp_hit_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic [31:0]         cycle_cnt_q, cycle_cnt_d;

  logic                run_db, step_db, step_pulse, bp_match;
  logic [NUM_BP-1:0]   match;

  // Conditioning for both raw controls: lane 0 = run, lane 1 = step.
  pdu_run_ctrl_sync_db #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_db [1:0] (
    .clk   (clk),
    .rst   (rst),
    .raw   ({step, run}),
    .level ({step_db, run_db})
  );

  // One comparator per breakpoint; lane i sees bp_addr[i*PC_W +: PC_W].
  pdu_run_ctrl_bp_cmp #(.PC_W(PC_W)) u_cmp [NUM_BP-1:0] (
    .en    (bp_en),
    .addr  (bp_addr),
    .pc    (pc),
    .match (match)
  );

  assign step_pulse = step_db && !step_prev_q;
  // The mask lets a resume execute the instruction it halted on once.
  assign bp_match   = (|match) && !resume_mask_q;
  // Gated by rst so a reset mid-run never leaks an extra enable cycle.
  assign cpu_ce     = rst && (state_q != ST_HALT) && !bp_match;

  // Next-state, breakpoint bookkeeping and step counting.
  always_comb begin
    state_d       = state_q;
    bp_hit_d      = bp_hit_q;
    rem_d         = rem_q;
    step_prev_d   = step_db;
    run_armed_d   = run_db ? run_armed_q : 1'b1;
    resume_mask_d = cpu_ce ? 1'b0 : resume_mask_q;
    cycle_cnt_d   = cycle_cnt_q + {31'd0, cpu_ce};
    case (state_q)
      ST_HALT: begin
        if (run_db && run_armed_q) begin
          state_d  = ST_RUN;
          bp_hit_d = '0;
        end else if (step_pulse) begin
          state_d  = ST_STEP;
          bp_hit_d = '0;
          rem_d    = (step_cnt == '0) ? STEP_W'(1) : step_cnt;
        end
      end
      ST_RUN: begin
        if (bp_match) begin
          state_d       = ST_HALT;
          bp_hit_d      = match;
          run_armed_d   = 1'b0;
          resume_mask_d = 1'b1;
        end else if (!run_db) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        // run and further step presses are deliberately ignored here.
        if (bp_match) begin
          state_d       = ST_HALT;
          bp_hit_d      = match;
          resume_mask_d = 1'b1;
        end else begin
          rem_d = rem_q - 1'b1;
          if (rem_q == STEP_W'(1)) state_d = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_HALT;
      halted_q      <= 1'b1;
      run_armed_q   <= 1'b1;
      resume_mask_q <= 1'b0;
      step_prev_q   <= 1'b0;
      bp_hit_q      <= '0;
      rem_q         <= '0;
      cycle_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      halted_q      <= halted_d;
      run_armed_q   <= run_armed_d;
      resume_mask_q <= resume_mask_d;
      step_prev_q   <= step_prev_d;
      bp_hit_q      <= bp_hit_d;
      rem_q         <= rem_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  assign halted    = halted_q;
  assign bp_hit    = bp_hit_q;
  assign cycle_cnt = cycle_cnt_q;
endmodule
